uart_frame_loader: RTL
======================

// Module: uart_frame_loader
// PURPOSE
// Hardware replacement for the soft-CPU path between the UART receiver and vgaController.
// Parses framed byte streams from uart (rx_dout/rx_rdy/rx_rdy_clr) and packs bytes into DATA_W words.
// Writes the words into one of NUM_BANKS video memories over the data/wraddress/wren/memorySel port.
// Adds multi-bank double buffering: the displayed bank flips only after a frame passes its checksum.
// PARAMETERS
// DATA_W      32      word width written to video memory; multiple of 8
// ADDR_W      6       word address width; one frame = 2**ADDR_W words
// NUM_BANKS   2       number of video memory banks; BANK_W = (NUM_BANKS>1) ? $clog2(NUM_BANKS) : 1
// SYNC_BYTE   8'hA5   frame start marker
// TIMEOUT_CYC 500000  max idle clk cycles between bytes inside a frame (10 ms @ 50 MHz)
// PORTS
// clk         in   1       system clock (50 MHz)
// rst         in   1       synchronous reset, active-low
// rx_dout     in   8       received byte from uart
// rx_rdy      in   1       uart byte valid; held until rx_rdy_clr seen
// rx_rdy_clr  out  1       one-cycle pulse: byte consumed
// data        out  DATA_W  word to video memory
// wraddress   out  ADDR_W  word address
// wren        out  1       one-cycle write strobe
// memorySel   out  BANK_W  bank being written
// disp_sel    out  BANK_W  bank to display; last frame with good checksum
// busy        out  1       high in any state except IDLE
// frame_done  out  1       one-cycle pulse: frame accepted
// frame_err   out  1       one-cycle pulse: frame rejected (bad bank, checksum, timeout)
// BEHAVIOUR
// Reset (rst==0 at posedge): all outputs 0; state IDLE; counters 0. Takes priority over everything, including mid-frame.
// Byte accept: occurs in a cycle where rx_rdy==1 && rx_rdy_clr==0.
//   rx_rdy_clr is 1 in the next cycle only. No accept is possible in the rx_rdy_clr==1 cycle.
//   Maximum rate is therefore one byte per 2 clks.
//   Every byte is acknowledged in every state, including discarded ones.
// Frame format: SYNC_BYTE, BANK, then 2**ADDR_W * DATA_W/8 payload bytes (MSB-first per word), then CHK.
//   CHK = XOR of all payload bytes.
// FSM states:
//   IDLE: discard bytes != SYNC_BYTE. On SYNC_BYTE -> HDR.
//   HDR: if BANK >= NUM_BANKS -> frame_err, -> IDLE.
//        Else memorySel<=BANK[BANK_W-1:0], wraddress<=0, checksum<=0, -> PAYLOAD.
//   PAYLOAD: shift byte into word register and XOR into checksum.
//     After the DATA_W/8-th byte of a word, the next cycle has wren=1 with data=word and wraddress=current index.
//     wraddress increments the cycle after wren. After the last word's wren -> CHK.
//     A SYNC_BYTE value inside the payload is plain data.
//   CHK: on accepted byte: match -> disp_sel<=memorySel, frame_done=1; else frame_err=1. Either way -> IDLE.
// Timeout: counter clears on every accept and runs in HDR/PAYLOAD/CHK.
//   Reaching TIMEOUT_CYC -> frame_err, -> IDLE. Words already written stay; disp_sel is unchanged.
// data, wraddress and memorySel hold their last values when wren==0. frame_done and frame_err are never both 1.
// Writing into the displayed bank is legal; the checksum only gates the disp_sel update.
// Arithmetic: wraddress wraps naturally at 2**ADDR_W, but the FSM leaves PAYLOAD before any wrap.
// TESTING (bench: DATA_W=32, ADDR_W=2, NUM_BANKS=2, TIMEOUT_CYC=100; uart model drops rx_rdy 1 clk after rx_rdy_clr)
// 1 Good frame A5,01,00..0F,CHK=00 -> 4 wren pulses: wraddress 0..3, data 00010203/04050607/08090A0B/0C0D0E0F, memorySel=1; frame_done; disp_sel=1.
// 2 Same frame, CHK=FF -> 4 wren pulses, frame_err, disp_sel keeps prior value, no frame_done.
// 3 Bad bank: A5,02,then 16 bytes -> frame_err after BANK byte, no wren, trailing bytes acked and discarded in IDLE.
// 4 Noise: 11,22,A5,00,payload,CHK -> each byte gets exactly one rx_rdy_clr pulse; frame to bank 0 succeeds; disp_sel=0.
// 5 Timeout: A5,00,5 bytes, then 101 idle clks -> frame_err, exactly 1 wren (wraddress 0), busy=0; a following good frame succeeds.
// 6 Reset: rst=0 for 1 clk mid-payload -> next clk all outputs 0; an immediately following good frame succeeds.
// 7 Back-to-back: rx_rdy held high continuously -> accept/clear alternate every clk, no byte consumed twice.

Source files
------------

// File: rtl/uart_frame_loader.sv
// Framed UART byte stream -> DATA_W word writes into one of NUM_BANKS video memories.
// The displayed bank (disp_sel) flips only after a complete frame passes its XOR checksum.
module uart_frame_loader #(
  parameter int         DATA_W      = 32,
  parameter int         ADDR_W      = 6,
  parameter int         NUM_BANKS   = 2,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 500000,
  localparam int        BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_dout,
  input  logic              rx_rdy,
  output logic              rx_rdy_clr,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] wraddress,
  output logic              wren,
  output logic [BANK_W-1:0] memorySel,
  output logic [BANK_W-1:0] disp_sel,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int BPW    = DATA_W / 8;
  localparam int BCNT_W = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_CHK} state_t;

  state_t              r_state;
  logic                r_clr;
  logic [DATA_W-1:0]   r_data;
  logic [ADDR_W-1:0]   r_wraddr;
  logic                r_wren;
  logic [BANK_W-1:0]   r_memsel;
  logic [BANK_W-1:0]   r_disp;
  logic                r_done;
  logic                r_err;
  logic [DATA_W-1:0]   r_word;
  logic [7:0]          r_chk;
  logic [BCNT_W-1:0]   r_bcnt;
  logic [TMO_W-1:0]    r_tmo;

  logic                w_accept;
  logic                w_tmo_hit;
  logic [DATA_W-1:0]   w_word_nxt;

  // A byte held on rx_rdy is never taken twice: the ack cycle itself blocks acceptance.
  assign w_accept   = rx_rdy && !r_clr;
  assign w_word_nxt = DATA_W'({r_word, rx_dout});
  assign w_tmo_hit  = (r_state != S_IDLE) && !w_accept && (r_tmo == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_clr    <= 1'b0;
      r_data   <= '0;
      r_wraddr <= '0;
      r_wren   <= 1'b0;
      r_memsel <= '0;
      r_disp   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_word   <= '0;
      r_chk    <= '0;
      r_bcnt   <= '0;
      r_tmo    <= '0;
    end else begin
      r_clr  <= w_accept;
      r_wren <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE || w_accept) r_tmo <= '0;
      else                               r_tmo <= r_tmo + 1'b1;

      case (r_state)
        S_IDLE: if (w_accept && rx_dout == SYNC_BYTE) r_state <= S_HDR;
        S_HDR: if (w_accept) begin
          if (32'(rx_dout) >= NUM_BANKS) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_memsel <= rx_dout[BANK_W-1:0];
            r_wraddr <= '0;
            r_chk    <= '0;
            r_bcnt   <= '0;
            r_state  <= S_PAY;
          end
        end
        S_PAY: begin
          if (w_accept) begin
            r_word <= w_word_nxt;
            r_chk  <= r_chk ^ rx_dout;
            if (r_bcnt == BCNT_W'(BPW - 1)) begin
              r_bcnt <= '0;
              r_data <= w_word_nxt;
              r_wren <= 1'b1;
            end else begin
              r_bcnt <= r_bcnt + 1'b1;
            end
          end
          // Address advances after the strobe; the last word leaves it parked at the top.
          if (r_wren) begin
            if (r_wraddr == {ADDR_W{1'b1}}) r_state  <= S_CHK;
            else                            r_wraddr <= r_wraddr + 1'b1;
          end
        end
        S_CHK: if (w_accept) begin
          if (rx_dout == r_chk) begin
            r_disp <= r_memsel;
            r_done <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_tmo_hit) begin
        r_err   <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end

  assign rx_rdy_clr = r_clr;
  assign data       = r_data;
  assign wraddress  = r_wraddr;
  assign wren       = r_wren;
  assign memorySel  = r_memsel;
  assign disp_sel   = r_disp;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = r_done;
  assign frame_err  = r_err;

endmodule
